detect_event_logger: RTL and testbench

Downstream consumer of the serial Moore sequence detector's 1-bit output `y`. It frames the detector's output stream into fixed-length bit frames and counts detection events. Each event's bit index within the frame is logged into a small show-ahead FIFO, which a host drains through a valid/read handshake. The testbench and top level use it to check detection positions without scraping `$write` output.

---
 rtl/detect_pkg.sv | 13 +
 rtl/detect_event_logger_fifo.sv | 50 +++++
 rtl/detect_event_logger.sv | 101 ++++++++++
 tb/tb_detect_event_logger.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Shared types and defaults for the detection event logger.
package detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } logger_state_t;

    localparam int FRAME_LEN_DEF = 64;
    localparam int IDX_W_DEF     = 6;

endpackage

// File: rtl/detect_event_logger_fifo.sv
// Show-ahead synchronous FIFO with flush; dout reads zero while empty.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this edge, so a push into a full FIFO may proceed.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/detect_event_logger.sv
// Frames the detector bit stream, counts events and logs their bit indices
// into a small FIFO drained by the host.
module detect_event_logger
    import detect_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             y,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [IDX_W-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logger_state_t    state_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;

    logic start_acc;
    logic evt;
    logic pop_req;
    logic drop;
    logic push;
    logic fifo_full;
    logic fifo_empty;

    assign start_acc = start && (state_q != RUN);
    assign evt       = (state_q == RUN) && en && y;
    assign pop_req   = rd_en && !fifo_empty;
    assign drop      = evt && fifo_full && !pop_req;
    assign push      = evt && !drop;
    assign count_d   = (count_q == '1) ? count_q : count_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q   <= RUN;
                        bit_idx_q <= '0;
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (y) count_q <= count_d;
                        if (drop) ovf_q <= 1'b1;
                        // Index parks at the last slot so it never exceeds FRAME_LEN-1.
                        if (bit_idx_q == LAST_IDX) state_q <= DONE;
                        else                       bit_idx_q <= bit_idx_q + IDX_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH(IDX_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(start_acc),
        .push (push),
        .din  (bit_idx_q),
        .pop  (rd_en),
        .dout (rd_data),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign rd_valid = !fifo_empty;
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_detect_event_logger.sv
// Scoreboard bench: logged indices are queued as stimulus is issued and
// compared by a monitor whenever the host pops.
module tb_detect_event_logger;

    logic       clk = 1'b0;
    logic       rst, start, en, y, rd_en;
    logic       rd_valid, ovf, busy, done;
    logic [5:0] rd_data;
    logic [6:0] count;

    logic       start2, en2, y2, rd_en2;
    logic       rd_valid2, ovf2, busy2, done2;
    logic [5:0] rd_data2;
    logic [3:0] count2;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    detect_event_logger dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .y(y), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .ovf(ovf),
        .busy(busy), .done(done)
    );

    detect_event_logger #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .en(en2), .y(y2), .rd_en(rd_en2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .count(count2), .ovf(ovf2),
        .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"},  rd_data,  0);
        chk({tag, "_count"},    count,    0);
        chk({tag, "_ovf"},      ovf,      0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_done"},     done,     0);
    endtask

    // Monitor: every accepted pop must match the oldest expected index.
    always @(negedge clk) begin
        if (rd_en && rd_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0d expected no entry", rd_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (rd_data !== 6'(e)) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0d expected %0d", rd_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; y = 1'b0; rd_en = 1'b0;
        start2 = 1'b0; en2 = 1'b0; y2 = 1'b0; rd_en2 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // Three isolated events in a full frame
        do_start();
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 64; i++) begin
            en = 1'b1;
            y  = (i == 5 || i == 17 || i == 40);
            if (y) exp_q.push_back(i);
            tick();
            if (i == 62) chk("t1_not_done_early", done, 0);
        end
        en = 1'b0; y = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_count", count, 3);
        drain(3);
        chk("t1_empty_valid", rd_valid, 0);
        chk("t1_empty_data", rd_data, 0);
        chk("t1_queue_drained", exp_q.size(), 0);

        // Overflow: ten consecutive events with no reads
        do_start();
        chk("t2_count_cleared", count, 0);
        chk("t2_flushed", rd_valid, 0);
        for (int i = 0; i < 64; i++) begin
            en = 1'b1;
            y  = (i < 10);
            if (y && i < 8) exp_q.push_back(i);
            tick();
            if (i == 7) chk("t2_ovf_before", ovf, 0);
            if (i == 8) chk("t2_ovf_set", ovf, 1);
        end
        en = 1'b0; y = 1'b0;
        chk("t2_count", count, 10);
        chk("t2_ovf_sticky", ovf, 1);
        chk("t2_done", done, 1);
        drain(8);
        chk("t2_empty", rd_valid, 0);

        // Push and pop together while full
        do_start();
        chk("t3_ovf_cleared", ovf, 0);
        for (int i = 0; i < 64; i++) begin
            en    = 1'b1;
            y     = (i <= 8);
            rd_en = (i == 8);
            if (y) exp_q.push_back(i);
            tick();
            rd_en = 1'b0;
            if (i == 8) chk("t3_ovf_after_pushpop", ovf, 0);
        end
        en = 1'b0; y = 1'b0;
        chk("t3_count", count, 9);
        chk("t3_ovf_final", ovf, 0);
        drain(8);
        chk("t3_empty", rd_valid, 0);
        chk("t3_queue_drained", exp_q.size(), 0);

        // y only while en is low: no events, 128 cycles per frame
        do_start();
        for (int c = 0; c < 128; c++) begin
            en = (c % 2 == 0);
            y  = !en;
            tick();
            if (c == 125) chk("t4_busy_before_last", busy, 1);
        end
        en = 1'b0; y = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_count", count, 0);
        chk("t4_empty", rd_valid, 0);

        // Mid-frame reset, then restart from DONE
        do_start();
        for (int i = 0; i < 30; i++) begin
            en = 1'b1;
            y  = (i == 3 || i == 10 || i == 20);
            tick();
        end
        chk("t5_queued", rd_valid, 1);
        chk("t5_count_pre", count, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0; y = 1'b0;
        chk_all_zero("t5_rst");
        en = 1'b1; y = 1'b1;
        repeat (3) tick();
        en = 1'b0; y = 1'b0;
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_count", count, 0);
        chk("t5_idle_fifo", rd_valid, 0);
        do_start();
        for (int i = 0; i < 64; i++) begin
            en = 1'b1;
            y  = (i == 63);
            if (y) exp_q.push_back(i);
            tick();
        end
        en = 1'b0; y = 1'b0;
        chk("t5_last_idx_count", count, 1);
        chk("t5_last_idx_done", done, 1);
        chk("t5_last_idx_data", rd_data, 63);
        do_start();
        exp_q.delete();
        chk("t5_restart_count", count, 0);
        chk("t5_restart_fifo", rd_valid, 0);
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_done", done, 0);

        // Counter saturation on a narrow counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("t6_busy", busy2, 1);
        for (int i = 0; i < 20; i++) begin
            en2 = 1'b1;
            y2  = 1'b1;
            tick();
            if (i == 13) chk("t6_count14", count2, 14);
            if (i == 14) chk("t6_count15", count2, 15);
        end
        en2 = 1'b0; y2 = 1'b0;
        chk("t6_saturated", count2, 15);
        chk("t6_ovf", ovf2, 1);
        chk("t6_valid", rd_valid2, 1);
        chk("t6_head", rd_data2, 0);
        chk("t6_not_done", done2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
